td4_program_loader: RTL and testbench

//  Serial program loader directly upstream of the 16x8 TD4 program memory.

---
 rtl/td4_pkg.sv | 30 +++
 rtl/td4_sync_edge.sv | 33 +++
 rtl/td4_program_loader.sv | 144 ++++++++++++++
 tb/tb_td4_program_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared TD4 definitions: memory geometry, loader state encoding and the
// instruction word field slices.
package td4_pkg;

  localparam int TD4_ADDR_BITS = 4;
  localparam int TD4_WORD_BITS = 8;
  localparam int TD4_WORDS     = 16;

  // Instruction word = {immediate[3:0], opcode[3:0]}
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 4;
  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_SHIFT = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_t;

  function automatic logic [3:0] word_imm(input logic [TD4_WORD_BITS-1:0] w);
    return w[IMM_MSB:IMM_LSB];
  endfunction

  function automatic logic [3:0] word_op(input logic [TD4_WORD_BITS-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/td4_sync_edge.sv
// Multi-flop synchronizer for a slow asynchronous pin, followed by one
// history flop so rising and falling edges of the synchronized level can be
// flagged for a single clk.
module td4_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Shift the pin through the synchronizer chain and keep the last level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = q & ~prev_r;
  assign fall = ~q & prev_r;

endmodule

// File: rtl/td4_program_loader.sv
// Serial program loader for the 16x8 TD4 program memory. Three slow pins
// (ld_mode, ld_sck, ld_sdi) deliver MSB-first 8-bit words which are written
// to consecutive addresses starting at 0 while the CPU is held halted.
// Leaving load mode releases the CPU and requests a restart.
//
// Write port contract: mem_write is a single-cycle strobe with no
// back-pressure; mem_address/mem_opcode/mem_immediate are valid in the same
// cycle and hold their last values afterwards.
module td4_program_loader
  import td4_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORDS       = TD4_WORDS,
  parameter int ADDR_BITS   = TD4_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_mode,
  input  logic                 ld_sck,
  input  logic                 ld_sdi,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [3:0]           mem_opcode,
  output logic [3:0]           mem_immediate,
  output logic                 mem_write,
  output logic                 cpu_halt,
  output logic                 cpu_restart,
  output logic                 load_complete,
  output logic [1:0]           dbg_state
);

  localparam logic [ADDR_BITS:0] LAST_WORD = (ADDR_BITS+1)'(WORDS-1);
  localparam logic [ADDR_BITS:0] CNT_ONE   = (ADDR_BITS+1)'(1);

  logic mode_q, mode_rise, mode_fall;
  logic sck_q, sck_rise, sck_fall;
  logic sdi_q, sdi_rise, sdi_fall;

  td4_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk(clk), .rst_n(rst_n), .d(ld_mode),
    .q(mode_q), .rise(mode_rise), .fall(mode_fall)
  );

  td4_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(ld_sck),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  td4_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .d(ld_sdi),
    .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall)
  );

  // Only the mode level/rise, the sck rise and the sdi level drive the FSM.
  logic unused_edges;
  assign unused_edges = ^{mode_fall, sck_q, sck_fall, sdi_rise, sdi_fall};

  ld_state_t              state;
  logic [TD4_WORD_BITS-1:0] shreg;
  logic [3:0]             bitcnt;
  logic [ADDR_BITS:0]     wcnt;

  assign dbg_state = state;

  // Loader FSM with shifter, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LD_IDLE;
      shreg         <= '0;
      bitcnt        <= '0;
      wcnt          <= '0;
      mem_address   <= '0;
      mem_opcode    <= '0;
      mem_immediate <= '0;
      mem_write     <= 1'b0;
      cpu_halt      <= 1'b0;
      cpu_restart   <= 1'b0;
      load_complete <= 1'b0;
    end else begin
      mem_write   <= 1'b0;
      cpu_restart <= 1'b0;
      case (state)
        LD_IDLE: begin
          if (mode_rise) begin
            state         <= LD_SHIFT;
            cpu_halt      <= 1'b1;
            wcnt          <= '0;
            bitcnt        <= '0;
            load_complete <= 1'b0;
          end
        end
        LD_SHIFT: begin
          if (!mode_q) begin
            // Partial word is dropped; written words stay in memory.
            state       <= LD_IDLE;
            cpu_halt    <= 1'b0;
            cpu_restart <= 1'b1;
          end else if (bitcnt == 4'd8) begin
            state         <= LD_WRITE;
            mem_write     <= 1'b1;
            mem_address   <= wcnt[ADDR_BITS-1:0];
            mem_opcode    <= word_op(shreg);
            mem_immediate <= word_imm(shreg);
          end else if (sck_rise) begin
            shreg  <= {shreg[TD4_WORD_BITS-2:0], sdi_q};
            bitcnt <= bitcnt + 4'd1;
          end
        end
        LD_WRITE: begin
          // The strobe issued on entry completes regardless of mode.
          wcnt   <= wcnt + CNT_ONE;
          bitcnt <= '0;
          if (wcnt == LAST_WORD) begin
            load_complete <= 1'b1;
          end
          if (!mode_q) begin
            state       <= LD_IDLE;
            cpu_halt    <= 1'b0;
            cpu_restart <= 1'b1;
          end else if (wcnt == LAST_WORD) begin
            state <= LD_DONE;
          end else begin
            state <= LD_SHIFT;
            // An sck edge landing here is the first bit of the next word.
            if (sck_rise) begin
              shreg  <= {shreg[TD4_WORD_BITS-2:0], sdi_q};
              bitcnt <= 4'd1;
            end
          end
        end
        LD_DONE: begin
          if (!mode_q) begin
            state       <= LD_IDLE;
            cpu_halt    <= 1'b0;
            cpu_restart <= 1'b1;
          end
        end
        default: begin
          state <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_td4_program_loader.sv
// Bench for the TD4 serial program loader: fixed vector table for a full
// load, hand-written corner sequences, and randomized sessions compared to a
// word-list/memory reference model.
module tb_td4_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_mode = 1'b0;
  logic       ld_sck = 1'b0;
  logic       ld_sdi = 1'b0;
  logic [3:0] mem_address;
  logic [3:0] mem_opcode;
  logic [3:0] mem_immediate;
  logic       mem_write;
  logic       cpu_halt;
  logic       cpu_restart;
  logic       load_complete;
  logic [1:0] dbg_state;

  td4_program_loader #(.SYNC_STAGES(2), .WORDS(16), .ADDR_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_mode(ld_mode), .ld_sck(ld_sck), .ld_sdi(ld_sdi),
    .mem_address(mem_address), .mem_opcode(mem_opcode),
    .mem_immediate(mem_immediate), .mem_write(mem_write),
    .cpu_halt(cpu_halt), .cpu_restart(cpu_restart),
    .load_complete(load_complete), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  int         restarts = 0;
  int         rbase;
  logic       prev_write = 1'b0;
  logic [11:0] obs_q[$];   // {addr, imm, op} as seen on the write port
  logic [11:0] exp_q[$];   // expected {addr, word}
  logic [7:0]  shadow[16]; // memory image built from observed writes
  logic [7:0]  model_mem[16];

  typedef struct {
    logic [7:0] word;
    logic [3:0] addr;
    logic [3:0] op;
    logic [3:0] imm;
  } vec_t;
  vec_t tbl[16];

  logic [3:0]  k4;
  logic [7:0]  w8;
  logic [11:0] e12;
  int          lat;
  logic        halt_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Write-port / restart monitor, sampled 1ns after the active edge.
  always @(posedge clk) begin
    #1;
    if (mem_write) begin
      chk("write_pulse_width", {31'd0, prev_write}, 32'd0);
      obs_q.push_back({mem_address, mem_immediate, mem_opcode});
      shadow[mem_address] = {mem_immediate, mem_opcode};
    end
    if (cpu_restart) begin
      restarts++;
      chk("halt_low_at_restart", {31'd0, cpu_halt}, 32'd0);
    end
    prev_write = mem_write;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ld_sdi = b;
    ld_sck = 1'b0;
    wait_clk(4);
    ld_sck = 1'b1;
    wait_clk(4);
    ld_sck = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) send_bit(w[b]);
  endtask

  task automatic start_session();
    obs_q.delete();
    ld_mode = 1'b1;
    wait_clk(5);
  endtask

  task automatic end_session();
    ld_mode = 1'b0;
    wait_clk(6);
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_mems();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  // Random session against the reference model: the first min(n,16) words
  // land at addresses 0.. in order; anything later or partial is dropped.
  task automatic random_session(input int idx);
    int n;
    int partial;
    logic [7:0] w;
    logic [11:0] got;
    logic [11:0] exp;
    n = $urandom_range(1, 18);
    partial = $urandom_range(0, 7);
    exp_q.delete();
    rbase = restarts;
    start_session();
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom_range(0, 255));
      if (i < 16) begin
        exp_q.push_back({4'(i), w});
        model_mem[i] = w;
      end
      send_word(w);
    end
    for (int i = 0; i < partial; i++) send_bit(1'($urandom_range(0, 1)));
    wait_clk(3);
    chk($sformatf("rnd%0d_load_complete", idx), {31'd0, load_complete}, {31'd0, (n >= 16)});
    end_session();
    chk($sformatf("rnd%0d_restart", idx), restarts - rbase, 1);
    chk($sformatf("rnd%0d_write_count", idx), obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = obs_q.pop_front();
      chk($sformatf("rnd%0d_write", idx), {20'd0, got}, {20'd0, exp});
    end
    for (int a = 0; a < 16; a++)
      chk($sformatf("rnd%0d_mem%0d", idx, a), {24'd0, shadow[a]}, {24'd0, model_mem[a]});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_mems();
    for (int i = 0; i < 16; i++) begin
      k4 = 4'(i);
      tbl[i].word = {k4, ~k4};
      tbl[i].addr = k4;
      tbl[i].op   = ~k4;
      tbl[i].imm  = k4;
    end

    // Reset state
    wait_clk(3);
    chk("reset_outputs",
        {14'd0, mem_address, mem_opcode, mem_immediate, mem_write, cpu_halt, cpu_restart, load_complete},
        32'd0);
    rst_n = 1'b1;
    wait_clk(3);

    // 1: full load from the vector table
    rbase = restarts;
    start_session();
    chk("t1_halt_on_entry", {31'd0, cpu_halt}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      send_word(tbl[i].word);
      wait_clk(2);
      chk($sformatf("t1_count_%0d", i), obs_q.size(), i + 1);
      if (obs_q.size() > 0) begin
        e12 = obs_q[obs_q.size()-1];
        chk($sformatf("t1_addr_%0d", i), {28'd0, e12[11:8]}, {28'd0, tbl[i].addr});
        chk($sformatf("t1_imm_%0d", i), {28'd0, e12[7:4]}, {28'd0, tbl[i].imm});
        chk($sformatf("t1_op_%0d", i), {28'd0, e12[3:0]}, {28'd0, tbl[i].op});
      end
    end
    chk("t1_load_complete", {31'd0, load_complete}, 32'd1);
    chk("t1_halt_before_exit", {31'd0, cpu_halt}, 32'd1);
    end_session();
    chk("t1_restart_once", restarts - rbase, 1);
    chk("t1_halt_after_exit", {31'd0, cpu_halt}, 32'd0);

    // 2: latency from 8th pin rise to write strobe, stream 1011_0011
    start_session();
    w8 = 8'hB3;
    for (int b = 7; b >= 1; b--) send_bit(w8[b]);
    ld_sdi = w8[0];
    ld_sck = 1'b0;
    wait_clk(4);
    ld_sck = 1'b1;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_write) break;
    end
    chk("t2_latency", lat, 4);
    chk("t2_addr", {28'd0, mem_address}, 32'd0);
    chk("t2_data", {24'd0, mem_immediate, mem_opcode}, 32'hB3);
    @(posedge clk);
    #2;
    chk("t2_strobe_width", {31'd0, mem_write}, 32'd0);
    wait_clk(4);
    ld_sck = 1'b0;
    end_session();

    // 3: abort after 3 words + 5 bits, then a fresh session
    rbase = restarts;
    start_session();
    for (int i = 0; i < 3; i++) send_word(8'(8'h21 * (i + 1)));
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    end_session();
    chk("t3_write_count", obs_q.size(), 3);
    chk("t3_restart", restarts - rbase, 1);
    chk("t3_load_complete", {31'd0, load_complete}, 32'd0);
    chk("t3_halt", {31'd0, cpu_halt}, 32'd0);
    start_session();
    send_word(8'h5A);
    wait_clk(2);
    chk("t3_new_count", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("t3_new_addr0", {20'd0, obs_q[0]}, 32'h05A);
    end_session();

    // 4: overrun with 17 words
    rbase = restarts;
    start_session();
    for (int i = 0; i < 17; i++) send_word(8'(i * 7 + 3));
    wait_clk(3);
    chk("t4_write_count", obs_q.size(), 16);
    chk("t4_addr_stays_15", {28'd0, mem_address}, 32'd15);
    chk("t4_load_complete", {31'd0, load_complete}, 32'd1);
    chk("t4_halt_in_done", {31'd0, cpu_halt}, 32'd1);
    end_session();
    chk("t4_restart", restarts - rbase, 1);

    // 5: async reset at bit 4 of word 2
    start_session();
    send_word(8'h11);
    send_word(8'h22);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rbase = restarts;
    #2;
    rst_n = 1'b0;
    ld_mode = 1'b0;
    #1;
    chk("t5_async_outputs",
        {14'd0, mem_address, mem_opcode, mem_immediate, mem_write, cpu_halt, cpu_restart, load_complete},
        32'd0);
    clear_mems();
    wait_clk(4);
    chk("t5_no_restart", restarts - rbase, 0);
    rst_n = 1'b1;
    wait_clk(3);
    start_session();
    send_word(8'hC4);
    wait_clk(2);
    chk("t5_fresh_count", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("t5_fresh_addr0", {20'd0, obs_q[0]}, 32'h0C4);
    end_session();

    // 6: pin activity with ld_mode low
    obs_q.delete();
    rbase = restarts;
    halt_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ld_sck = 1'($urandom_range(0, 1));
      ld_sdi = 1'($urandom_range(0, 1));
      wait_clk($urandom_range(1, 6));
      halt_seen = halt_seen | cpu_halt;
    end
    ld_sck = 1'b0;
    wait_clk(4);
    chk("t6_no_writes", obs_q.size(), 0);
    chk("t6_no_halt", {31'd0, halt_seen}, 32'd0);
    chk("t6_no_restart", restarts - rbase, 0);

    // Randomized sessions against the reference model
    pulse_reset();
    for (int s = 0; s < 6; s++) random_session(s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #3000000;
    $display("FAIL timeout actual=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
